// File: rtl/lcd_bus_reader.sv
// -----------------------------------------------------------------------------
// lcd_bus_reader
//
// Read-side master for an HD44780-compatible 8-bit LCD bus (RW=1 cycles).
// The block performs three kinds of transaction:
//   * status read (RS=0): captures the busy flag (BF) and the 7-bit address counter
//   * data read   (RS=1): captures a DDRAM/CGRAM byte
//   * poll              : repeats status reads until BF=0 or a timeout expires
// A top-level pin mux hands lcd_rs/lcd_rw/lcd_en to this block while
// lcd_data_oe=0. While lcd_data_oe=1, a writer may drive the bus.
//
// Ports
//   clk, reset_n   system clock; synchronous, active-low reset
//   req, req_mode  start request (sampled in IDLE only); 0=status, 1=data,
//                  2=poll, 3=status
//   busy, done     transaction in progress; one-cycle completion pulse
//   rd_data        last byte sampled from the bus
//   busy_flag      BF from the last status/poll read
//   addr_cnt       address counter from the last status/poll read
//   timeout        the poll ended with BF still set (valid with done; held
//                  until the next accept)
//   lcd_data_in    LCD data pins (input side of the tristate)
//   lcd_data_oe    1 = a writer may drive the bus, 0 = the bus is released
//   lcd_rs/rw/en   LCD control pins
// -----------------------------------------------------------------------------
module lcd_bus_reader #(
  parameter int SETUP_CYC    = 2000,
  parameter int EN_HIGH_CYC  = 50,
  parameter int HOLD_CYC     = 25,
  parameter int POLL_GAP_CYC = 500,
  parameter int TIMEOUT_CYC  = 500000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req,
  input  logic [1:0] req_mode,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       busy_flag,
  output logic [6:0] addr_cnt,
  output logic       timeout,
  input  logic [7:0] lcd_data_in,
  output logic       lcd_data_oe,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_EN_HIGH,
    S_HOLD,
    S_GAP,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    MODE_STATUS = 2'd0,
    MODE_DATA   = 2'd1,
    MODE_POLL   = 2'd2
  } mode_t;

  // The phase counter must hold the longest timed state.
  localparam int MAX_AB  = (SETUP_CYC > EN_HIGH_CYC) ? SETUP_CYC : EN_HIGH_CYC;
  localparam int MAX_CD  = (HOLD_CYC > POLL_GAP_CYC) ? HOLD_CYC : POLL_GAP_CYC;
  localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int TW      = $clog2(TIMEOUT_CYC + 1);

  state_t        state, state_n;
  mode_t         mode_q, mode_n;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;

  logic       accept;
  logic       tcnt_hit;
  logic       busy_n, done_n, en_n, rw_n, rs_n, oe_n;

  assign accept   = (state == S_IDLE) && req;
  // The timeout counter saturates at TIMEOUT_CYC. Reaching that value
  // therefore means "at least TIMEOUT_CYC cycles since accept".
  assign tcnt_hit = (tcnt == TW'(TIMEOUT_CYC));

  // Next-state logic
  // NOTE: every signal driven by an always_comb gets a default first.
  // Without one, a path that does not assign it infers a latch.
  always_comb begin
    state_n = state;
    mode_n  = mode_q;
    unique case (state)
      S_IDLE: begin
        if (req) begin
          state_n = S_SETUP;
          unique case (req_mode)
            2'd1:    mode_n = MODE_DATA;
            2'd2:    mode_n = MODE_POLL;
            default: mode_n = MODE_STATUS;  // 3 is reserved and maps to status
          endcase
        end
      end
      S_SETUP:   if (cnt == CW'(SETUP_CYC - 1))   state_n = S_EN_HIGH;
      S_EN_HIGH: if (cnt == CW'(EN_HIGH_CYC - 1)) state_n = S_HOLD;
      S_HOLD: begin
        if (cnt == CW'(HOLD_CYC - 1)) begin
          // rd_data already holds this pass's sample; bit 7 is BF.
          if (mode_q != MODE_POLL || !rd_data[7] || tcnt_hit) state_n = S_DONE;
          else                                                state_n = S_GAP;
        end
      end
      S_GAP:     if (cnt == CW'(POLL_GAP_CYC - 1)) state_n = S_SETUP;
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // Output values for the state being entered. They are registered below, so
  // every pin changes on the same edge as the state.
  always_comb begin
    busy_n = 1'b1;
    done_n = 1'b0;
    en_n   = 1'b0;
    rw_n   = 1'b1;
    rs_n   = (mode_n == MODE_DATA);
    oe_n   = 1'b0;
    unique case (state_n)
      S_IDLE: begin
        busy_n = 1'b0;
        rw_n   = 1'b0;
        rs_n   = 1'b0;
        oe_n   = 1'b1;
      end
      S_EN_HIGH: en_n = 1'b1;
      S_GAP:     rw_n = 1'b0;  // This block still owns the bus (oe stays 0).
      S_DONE: begin
        done_n = 1'b1;
        rw_n   = 1'b0;
        rs_n   = 1'b0;
        oe_n   = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // update together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      mode_q      <= MODE_STATUS;
      cnt         <= '0;
      tcnt        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_data     <= 8'h00;
      busy_flag   <= 1'b0;
      addr_cnt    <= 7'h00;
      timeout     <= 1'b0;
      lcd_en      <= 1'b0;
      lcd_rw      <= 1'b0;
      lcd_rs      <= 1'b0;
      lcd_data_oe <= 1'b1;
    end else begin
      state  <= state_n;
      mode_q <= mode_n;

      // The phase counter restarts on every state change and idles at 0.
      if (state_n != state || state == S_IDLE) cnt <= '0;
      else                                     cnt <= cnt + 1'b1;

      if (accept)         tcnt <= '0;
      else if (!tcnt_hit) tcnt <= tcnt + 1'b1;

      // Sample the bus on the edge that ends the EN-high phase.
      if (state == S_EN_HIGH && state_n == S_HOLD) begin
        rd_data <= lcd_data_in;
        if (mode_q != MODE_DATA) begin
          busy_flag <= lcd_data_in[7];
          addr_cnt  <= lcd_data_in[6:0];
        end
      end

      if (accept)
        timeout <= 1'b0;
      else if (state == S_HOLD && state_n == S_DONE && mode_q == MODE_POLL && rd_data[7])
        timeout <= 1'b1;

      busy        <= busy_n;
      done        <= done_n;
      lcd_en      <= en_n;
      lcd_rw      <= rw_n;
      lcd_rs      <= rs_n;
      lcd_data_oe <= oe_n;
    end
  end

endmodule

// File: tb/tb_lcd_bus_reader.sv
// -----------------------------------------------------------------------------
// tb_lcd_bus_reader
//
// Self-checking bench for lcd_bus_reader with short timing parameters.
// Cycle k of a transaction is the k-th clock period after the accepting edge.
// For each transaction the bench records per-cycle bitmaps of lcd_en, lcd_rw,
// lcd_rs, lcd_data_oe and busy. It compares them against maps built from the
// timing parameters.
// -----------------------------------------------------------------------------
module tb_lcd_bus_reader;

  localparam int SETUP  = 4;
  localparam int ENH    = 3;
  localparam int HOLD   = 2;
  localparam int GAP    = 5;
  localparam int TOUT   = 100;
  localparam int PERIOD = SETUP + ENH + HOLD + GAP;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req;
  logic [1:0] req_mode;
  logic       busy, done, busy_flag, timeout;
  logic [7:0] rd_data;
  logic [6:0] addr_cnt;
  logic [7:0] lcd_data_in;
  logic       lcd_data_oe, lcd_rs, lcd_rw, lcd_en;

  int errors = 0;
  int checks = 0;

  lcd_bus_reader #(
    .SETUP_CYC   (SETUP),
    .EN_HIGH_CYC (ENH),
    .HOLD_CYC    (HOLD),
    .POLL_GAP_CYC(GAP),
    .TIMEOUT_CYC (TOUT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_mode   (req_mode),
    .busy       (busy),
    .done       (done),
    .rd_data    (rd_data),
    .busy_flag  (busy_flag),
    .addr_cnt   (addr_cnt),
    .timeout    (timeout),
    .lcd_data_in(lcd_data_in),
    .lcd_data_oe(lcd_data_oe),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_en     (lcd_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // lcd_en may only be high while the bus is released and RW=1.
  always @(negedge clk) check("en_invariant", lcd_en && (lcd_data_oe || !lcd_rw), 1'b0);

  typedef struct {
    logic [1:0] mode;
    logic [7:0] d_busy;    // returned for the first n_busy samples
    int         n_busy;
    logic [7:0] d_final;   // returned afterwards
    int         req_again; // cycle in which a stray req pulse is driven (0 = none)
    int         polls;     // expected number of EN pulses
    logic [7:0] exp_rd;
    logic       exp_bf;
    logic [6:0] exp_ac;
    logic       exp_to;
  } vec_t;

  vec_t vecs[7];

  task automatic run_txn(input vec_t v, input int idx);
    logic [255:0] en_map, rw_map, rs_map, oe_lo_map, busy_map;
    logic [255:0] x_en, x_rw, x_rs, x_oe_lo, x_busy;
    int done_cyc, done_cnt, samples, exp_done;
    logic prev_en;
    string tag;
    en_map = '0; rw_map = '0; rs_map = '0; oe_lo_map = '0; busy_map = '0;
    done_cyc = 0; done_cnt = 0; samples = 0; prev_en = 1'b0;
    tag = $sformatf("v%0d", idx);

    lcd_data_in = (v.n_busy > 0) ? v.d_busy : v.d_final;
    req_mode    = v.mode;
    req         = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    for (int k = 1; k < 250; k++) begin
      req = (k == v.req_again);
      @(negedge clk);
      en_map[k]    = lcd_en;
      rw_map[k]    = lcd_rw;
      rs_map[k]    = lcd_rs;
      oe_lo_map[k] = !lcd_data_oe;
      busy_map[k]  = busy;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = k;
          check({tag, "_rd_data"},   rd_data,   v.exp_rd);
          check({tag, "_busy_flag"}, busy_flag, v.exp_bf);
          check({tag, "_addr_cnt"},  addr_cnt,  v.exp_ac);
          check({tag, "_timeout"},   timeout,   v.exp_to);
        end
      end
      if (prev_en && !lcd_en) begin
        samples++;
        lcd_data_in = (samples < v.n_busy) ? v.d_busy : v.d_final;
      end
      prev_en = lcd_en;
      @(posedge clk); #1;
      if (done_cyc != 0 && k >= done_cyc + 3) break;
    end
    req = 1'b0;

    // Expected activity built from the timing parameters.
    exp_done = PERIOD * (v.polls - 1) + SETUP + ENH + HOLD + 1;
    x_en = '0; x_rw = '0; x_rs = '0; x_oe_lo = '0; x_busy = '0;
    for (int p = 0; p < v.polls; p++) begin
      for (int c = 1; c <= SETUP + ENH + HOLD; c++) x_rw[PERIOD * p + c] = 1'b1;
      for (int c = SETUP + 1; c <= SETUP + ENH; c++) x_en[PERIOD * p + c] = 1'b1;
    end
    for (int c = 1; c <= exp_done; c++) begin
      x_busy[c] = 1'b1;
      if (c < exp_done) begin
        x_oe_lo[c] = 1'b1;
        if (v.mode == 2'd1) x_rs[c] = 1'b1;
      end
    end
    check({tag, "_done_cycle"}, done_cyc,  exp_done);
    check({tag, "_done_count"}, done_cnt,  1);
    check({tag, "_en_map"},     en_map,    x_en);
    check({tag, "_rw_map"},     rw_map,    x_rw);
    check({tag, "_rs_map"},     rs_map,    x_rs);
    check({tag, "_oe_lo_map"},  oe_lo_map, x_oe_lo);
    check({tag, "_busy_map"},   busy_map,  x_busy);
    check({tag, "_timeout_held"}, timeout, v.exp_to);
  endtask

  initial begin
    logic [255:0] done_map;
    int           got_done;

    //        mode   d_busy n_busy d_final again polls rd     bf    ac     to
    vecs[0] = '{2'd0, 8'h00, 0,    8'h8A,  6,    1,    8'h8A, 1'b1, 7'h0A, 1'b0};
    vecs[1] = '{2'd0, 8'h00, 0,    8'h05,  0,    1,    8'h05, 1'b0, 7'h05, 1'b0};
    vecs[2] = '{2'd1, 8'h00, 0,    8'h41,  0,    1,    8'h41, 1'b0, 7'h05, 1'b0};
    vecs[3] = '{2'd2, 8'h93, 2,    8'h13,  0,    3,    8'h13, 1'b0, 7'h13, 1'b0};
    vecs[4] = '{2'd2, 8'hFF, 1000, 8'hFF,  0,    8,    8'hFF, 1'b1, 7'h7F, 1'b1};
    vecs[5] = '{2'd3, 8'h00, 0,    8'h22,  0,    1,    8'h22, 1'b0, 7'h22, 1'b0};
    vecs[6] = '{2'd1, 8'h00, 0,    8'hC7,  0,    1,    8'hC7, 1'b0, 7'h22, 1'b0};

    // Reset with req held high
    reset_n = 1'b0; req = 1'b1; req_mode = 2'd0; lcd_data_in = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",    busy,        1'b0);
    check("rst_done",    done,        1'b0);
    check("rst_rd_data", rd_data,     8'h00);
    check("rst_bf",      busy_flag,   1'b0);
    check("rst_ac",      addr_cnt,    7'h00);
    check("rst_timeout", timeout,     1'b0);
    check("rst_pins",    {lcd_en, lcd_rw, lcd_rs, lcd_data_oe}, 4'b0001);
    req = 1'b0;
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_busy", busy, 1'b0);
    end
    @(posedge clk); #1;

    // Table-driven transactions
    for (int i = 0; i < 7; i++) run_txn(vecs[i], i);

    // req held high through DONE: re-accepted on the first IDLE cycle
    done_map = '0;
    req_mode = 2'd0; lcd_data_in = 8'h30; req = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      done_map[k] = done;
      if (k == 21) req = 1'b0;
      if (k == 24) check("reaccept_busy_after", busy, 1'b0);
      @(posedge clk); #1;
    end
    check("reaccept_done_map", done_map, (256'd1 << 10) | (256'd1 << 21));

    // Reset during EN_HIGH aborts without a done pulse
    req_mode = 2'd0; lcd_data_in = 8'h8A; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    @(negedge clk);
    check("abort_en_before", lcd_en, 1'b1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_en",   lcd_en,      1'b0);
    check("abort_oe",   lcd_data_oe, 1'b1);
    check("abort_busy", busy,        1'b0);
    check("abort_rd",   rd_data,     8'h00);
    reset_n = 1'b1;
    got_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done || busy) got_done++;
    end
    check("abort_no_done", got_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
